refresh_sequencer: RTL and testbench

Consumes the refresh request from the refresh controller and turns it into a legal DDR3 command sequence: drain user traffic, PRECHARGE ALL if any bank is open, wait tRP, issue REFRESH, wait tRFC. It sits between the refresh controller and the command-bus arbiter. It returns ref_ack to the refresh controller and holds off the user scheduler for the whole sequence.

---
 rtl/ddr3_pkg.sv | 26 ++
 rtl/timing_down_counter.sv | 30 +++
 rtl/refresh_sequencer.sv | 129 ++++++++++++
 tb/tb_refresh_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
// Shared DDR3 controller types: command encoding, refresh-sequencer states, timing width.
// Also holds a small saturating-increment helper used by the optional refresh statistics.
package ddr3_pkg;

   localparam int TW_DEFAULT = 16;

   typedef enum logic [1:0] {
      CMD_NOP  = 2'd0,
      CMD_PREA = 2'd1,
      CMD_REF  = 2'd2
   } cmd_type_e;

   typedef enum logic [2:0] {
      SEQ_IDLE     = 3'd0,
      SEQ_DRAIN    = 3'd1,
      SEQ_PREA     = 3'd2,
      SEQ_WAIT_RP  = 3'd3,
      SEQ_REF      = 3'd4,
      SEQ_WAIT_RFC = 3'd5
   } seq_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/timing_down_counter.sv
// Loadable down-counter for DRAM timing waits; holds at zero instead of wrapping.
// 'one' flags the final count so callers can leave a wait state without an extra cycle.
module timing_down_counter import ddr3_pkg::*; #(
   parameter int TW = TW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   input  logic          dec,
   output logic          zero,
   output logic          one
);

   logic [TW-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !zero) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);
   assign one  = (count == TW'(1));

endmodule

// File: rtl/refresh_sequencer.sv
// DDR3 refresh sequencer: drain user traffic, PRECHARGE ALL if needed, wait tRP, REFRESH, wait tRFC.
// Optional statistics outputs (ref_count, max_ref_latency) are built when REF_STATS_EN is defined.
module refresh_sequencer import ddr3_pkg::*; #(
   parameter int NUM_BANKS = 8,
   parameter int TW        = TW_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ref_req,
   output logic                 ref_ack,
   input  logic [TW-1:0]        tRP,
   input  logic [TW-1:0]        tRFC,
   input  logic [NUM_BANKS-1:0] bank_open,
   input  logic                 user_idle,
   output logic                 cmd_valid,
   output logic [1:0]           cmd_type,
   input  logic                 cmd_grant,
   output logic                 hold_user,
   output logic                 ref_busy
`ifdef REF_STATS_EN
   ,
   output logic [15:0]          ref_count,
   output logic [15:0]          max_ref_latency
`endif
);

   seq_state_e    state, next_state;
   cmd_type_e     cmd_e;
   logic          cnt_load, cnt_dec, cnt_zero, cnt_one;
   logic [TW-1:0] cnt_val;

   function automatic logic [TW-1:0] wait_load(input logic [TW-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

   timing_down_counter #(.TW(TW)) u_wait_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero),
      .one      (cnt_one)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= SEQ_IDLE;
      else          state <= next_state;
   end

   // The grant cycle counts as the first cycle of the wait, so a zero load skips the wait state
   // and a wait state is left on its last count rather than one cycle after reaching zero.
   always_comb begin
      next_state = state;
      cnt_load   = 1'b0;
      cnt_val    = '0;
      cnt_dec    = (state == SEQ_WAIT_RP) || (state == SEQ_WAIT_RFC);
      case (state)
         SEQ_IDLE:     if (ref_req) next_state = SEQ_DRAIN;
         SEQ_DRAIN:    if (user_idle) next_state = (|bank_open) ? SEQ_PREA : SEQ_REF;
         SEQ_PREA: begin
            if (cmd_grant) begin
               cnt_load   = 1'b1;
               cnt_val    = wait_load(tRP);
               next_state = (cnt_val == '0) ? SEQ_REF : SEQ_WAIT_RP;
            end
         end
         SEQ_WAIT_RP:  if (cnt_one || cnt_zero) next_state = SEQ_REF;
         SEQ_REF: begin
            if (cmd_grant) begin
               cnt_load   = 1'b1;
               cnt_val    = wait_load(tRFC);
               next_state = (cnt_val == '0) ? SEQ_IDLE : SEQ_WAIT_RFC;
            end
         end
         SEQ_WAIT_RFC: if (cnt_one || cnt_zero) next_state = SEQ_IDLE;
         default:      next_state = SEQ_IDLE;
      endcase
   end

   always_comb begin
      cmd_e     = CMD_NOP;
      cmd_valid = 1'b0;
      if (state == SEQ_PREA) begin
         cmd_e     = CMD_PREA;
         cmd_valid = 1'b1;
      end else if (state == SEQ_REF) begin
         cmd_e     = CMD_REF;
         cmd_valid = 1'b1;
      end
   end

   assign cmd_type = cmd_e;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ref_ack   <= 1'b0;
         hold_user <= 1'b0;
         ref_busy  <= 1'b0;
      end else begin
         ref_ack   <= (state == SEQ_REF) && cmd_grant;
         hold_user <= (next_state != SEQ_IDLE);
         ref_busy  <= (next_state != SEQ_IDLE);
      end
   end

`ifdef REF_STATS_EN
   // lat_cnt is cycles since entering DRAIN; the ack lands one cycle after the REF grant.
   logic [15:0] lat_cnt;
   logic [15:0] lat_at_ack;

   assign lat_at_ack = sat_inc16(lat_cnt);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lat_cnt         <= '0;
         ref_count       <= '0;
         max_ref_latency <= '0;
      end else begin
         lat_cnt <= (state == SEQ_IDLE) ? 16'd0 : sat_inc16(lat_cnt);
         if ((state == SEQ_REF) && cmd_grant) begin
            ref_count <= sat_inc16(ref_count);
            if (lat_at_ack > max_ref_latency) max_ref_latency <= lat_at_ack;
         end
      end
   end
`endif

endmodule

// File: tb/tb_refresh_sequencer.sv
// Directed bench for refresh_sequencer; statistics checks are built when REF_STATS_EN is defined.
module tb_refresh_sequencer;
   import ddr3_pkg::*;

   localparam int NB = 8;
   localparam int TWB = 16;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            ref_req;
   logic            ref_ack;
   logic [TWB-1:0]  tRP;
   logic [TWB-1:0]  tRFC;
   logic [NB-1:0]   bank_open;
   logic            user_idle;
   logic            cmd_valid;
   logic [1:0]      cmd_type;
   logic            cmd_grant;
   logic            hold_user;
   logic            ref_busy;
`ifdef REF_STATS_EN
   logic [15:0]     ref_count;
   logic [15:0]     max_ref_latency;
`endif

   int checks   = 0;
   int failures = 0;

   refresh_sequencer #(.NUM_BANKS(NB), .TW(TWB)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ref_req   (ref_req),
      .ref_ack   (ref_ack),
      .tRP       (tRP),
      .tRFC      (tRFC),
      .bank_open (bank_open),
      .user_idle (user_idle),
      .cmd_valid (cmd_valid),
      .cmd_type  (cmd_type),
      .cmd_grant (cmd_grant),
      .hold_user (hold_user),
      .ref_busy  (ref_busy)
`ifdef REF_STATS_EN
      ,
      .ref_count       (ref_count),
      .max_ref_latency (max_ref_latency)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; ref_req = 1'b0; tRP = 16'd1; tRFC = 16'd1;
      bank_open = '0; user_idle = 1'b1; cmd_grant = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({ref_ack, cmd_valid, cmd_type, hold_user, ref_busy} !== 6'b0) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected 000000", {ref_ack, cmd_valid, cmd_type, hold_user, ref_busy});
      end
      reset_n = 1'b1;
      tick;
      checks++;
      if ({cmd_valid, ref_busy} !== 2'b00) begin
         failures++;
         $display("FAIL reset_release_idle: got %b expected 00", {cmd_valid, ref_busy});
      end
   endtask

   task automatic test_banks_closed;
      bank_open = '0; user_idle = 1'b1; tRP = 16'd3; tRFC = 16'd10; cmd_grant = 1'b1;
      ref_req = 1'b1;
      tick;                                   // c1: DRAIN
      ref_req = 1'b0;
      checks++;
      if (hold_user !== 1'b1 || cmd_valid !== 1'b0) begin
         failures++;
         $display("FAIL closed_drain: got hold=%b valid=%b expected hold=1 valid=0", hold_user, cmd_valid);
      end
      tick;                                   // c2: REF, no PREA in between
      checks++;
      if (cmd_valid !== 1'b1 || cmd_type !== 2'd2 || ref_ack !== 1'b0) begin
         failures++;
         $display("FAIL closed_ref: got valid=%b type=%0d ack=%b expected 1/2/0", cmd_valid, cmd_type, ref_ack);
      end
      tick;                                   // c3
      checks++;
      if (ref_ack !== 1'b1 || cmd_valid !== 1'b0) begin
         failures++;
         $display("FAIL closed_ack: got ack=%b valid=%b expected 1/0", ref_ack, cmd_valid);
      end
      tick;                                   // c4
      checks++;
      if (ref_ack !== 1'b0) begin
         failures++;
         $display("FAIL closed_ack_pulse: got %b expected 0", ref_ack);
      end
      repeat (7) tick;                        // c11
      checks++;
      if (hold_user !== 1'b1) begin
         failures++;
         $display("FAIL closed_hold_c11: got %b expected 1", hold_user);
      end
      tick;                                   // c12 = REF grant + 10
      checks++;
      if (hold_user !== 1'b0 || ref_busy !== 1'b0) begin
         failures++;
         $display("FAIL closed_hold_drop: got hold=%b busy=%b expected 0/0", hold_user, ref_busy);
      end
   endtask

   task automatic test_banks_open;
      int bad;
      bank_open = 8'h04; user_idle = 1'b1; tRP = 16'd5; tRFC = 16'd20; cmd_grant = 1'b1;
      ref_req = 1'b1;
      tick;                                   // c1
      ref_req = 1'b0;
      tick;                                   // c2: PREA granted
      checks++;
      if (cmd_valid !== 1'b1 || cmd_type !== 2'd1) begin
         failures++;
         $display("FAIL open_prea: got valid=%b type=%0d expected 1/1", cmd_valid, cmd_type);
      end
      tick;                                   // c3
      tRP = 16'd1;                            // must not disturb the count already loaded
      bad = 0;
      for (int c = 3; c <= 6; c++) begin
         if (cmd_valid !== 1'b0 || ref_busy !== 1'b1) bad++;
         tick;
      end                                     // c7
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL open_wait_rp: got %0d bad cycles expected 0", bad);
      end
      checks++;
      if (cmd_valid !== 1'b1 || cmd_type !== 2'd2) begin
         failures++;
         $display("FAIL open_ref_at_5: got valid=%b type=%0d expected 1/2", cmd_valid, cmd_type);
      end
      tick;                                   // c8
      checks++;
      if (ref_ack !== 1'b1) begin
         failures++;
         $display("FAIL open_ack: got %b expected 1", ref_ack);
      end
      bad = 0;
      for (int c = 8; c <= 26; c++) begin
         if (ref_busy !== 1'b1) bad++;
         tick;
      end                                     // c27 = REF grant + 20
      checks++;
      if (bad !== 0 || ref_busy !== 1'b0 || hold_user !== 1'b0) begin
         failures++;
         $display("FAIL open_rfc: got bad=%0d busy=%b hold=%b expected 0/0/0", bad, ref_busy, hold_user);
      end
   endtask

   task automatic test_drain;
      int bad;
      bank_open = '0; user_idle = 1'b0; tRFC = 16'd2; cmd_grant = 1'b1;
      ref_req = 1'b1;
      tick;                                   // c1
      ref_req = 1'b0;
      bad = 0;
      for (int c = 1; c <= 6; c++) begin
         if (cmd_valid !== 1'b0 || hold_user !== 1'b1) bad++;
         tick;
      end                                     // c7
      user_idle = 1'b1;
      if (cmd_valid !== 1'b0) bad++;
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL drain_hold: got %0d bad cycles expected 0", bad);
      end
      tick;                                   // c8
      checks++;
      if (cmd_valid !== 1'b1 || cmd_type !== 2'd2) begin
         failures++;
         $display("FAIL drain_ref: got valid=%b type=%0d expected 1/2", cmd_valid, cmd_type);
      end
      repeat (2) tick;                        // c10
      checks++;
      if (ref_busy !== 1'b0) begin
         failures++;
         $display("FAIL drain_done: got busy=%b expected 0", ref_busy);
      end
   endtask

   task automatic test_grant_stall;
      int bad;
      bank_open = 8'h01; user_idle = 1'b1; tRP = 16'd2; tRFC = 16'd3; cmd_grant = 1'b0;
      ref_req = 1'b1;
      tick;
      ref_req = 1'b0;
      tick;                                   // c2: PREA
      bad = 0;
      for (int c = 2; c <= 5; c++) begin
         if (cmd_valid !== 1'b1 || cmd_type !== 2'd1) bad++;
         tick;
      end                                     // c6
      cmd_grant = 1'b1;
      if (cmd_valid !== 1'b1 || cmd_type !== 2'd1) bad++;
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL stall_prea: got %0d unstable cycles expected 0", bad);
      end
      tick;                                   // c7: WAIT_RP
      cmd_grant = 1'b0;
      tick;                                   // c8: REF
      bad = 0;
      for (int c = 8; c <= 11; c++) begin
         if (cmd_valid !== 1'b1 || cmd_type !== 2'd2 || ref_ack !== 1'b0) bad++;
         tick;
      end                                     // c12
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL stall_ref: got %0d bad cycles expected 0", bad);
      end
      cmd_grant = 1'b1;
      tick;                                   // c13
      cmd_grant = 1'b0;
      checks++;
      if (ref_ack !== 1'b1) begin
         failures++;
         $display("FAIL stall_ack: got %b expected 1", ref_ack);
      end
      repeat (2) tick;                        // c15
      checks++;
      if (ref_busy !== 1'b0 || ref_ack !== 1'b0) begin
         failures++;
         $display("FAIL stall_done: got busy=%b ack=%b expected 0/0", ref_busy, ref_ack);
      end
   endtask

   task automatic test_reset_mid;
      int  acks;
      bit  prea_seen;
      bit  done;
      bank_open = '0; user_idle = 1'b1; tRFC = 16'd20; cmd_grant = 1'b1;
      ref_req = 1'b1;
      tick;
      ref_req = 1'b0;
      repeat (3) tick;                        // c4: WAIT_RFC
      checks++;
      if (ref_busy !== 1'b1) begin
         failures++;
         $display("FAIL rst_pre_busy: got %b expected 1", ref_busy);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({ref_ack, cmd_valid, cmd_type, hold_user, ref_busy} !== 6'b0) begin
         failures++;
         $display("FAIL rst_async: got %b expected 000000", {ref_ack, cmd_valid, cmd_type, hold_user, ref_busy});
      end
      repeat (2) tick;
      reset_n = 1'b1;
      tick;
      checks++;
      if (ref_busy !== 1'b0 || cmd_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_idle: got busy=%b valid=%b expected 0/0", ref_busy, cmd_valid);
      end
      bank_open = 8'h80; tRP = 16'd2; tRFC = 16'd3;
      ref_req = 1'b1;
      tick;
      ref_req = 1'b0;
      acks = 0; prea_seen = 1'b0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (cmd_valid === 1'b1 && cmd_type === 2'd1) prea_seen = 1'b1;
         if (ref_ack === 1'b1) acks++;
         if (ref_busy === 1'b0) done = 1'b1;
         else tick;
      end
      checks++;
      if (!done || !prea_seen || acks != 1) begin
         failures++;
         $display("FAIL rst_full_seq: got done=%b prea=%b acks=%0d expected 1/1/1", done, prea_seen, acks);
      end
   endtask

   task automatic test_back_to_back;
      bank_open = '0; user_idle = 1'b1; tRFC = 16'd1; cmd_grant = 1'b1;
      ref_req = 1'b1;
      repeat (3) tick;                        // c3: back in IDLE
      checks++;
      if (ref_ack !== 1'b1 || hold_user !== 1'b0) begin
         failures++;
         $display("FAIL b2b_first: got ack=%b hold=%b expected 1/0", ref_ack, hold_user);
      end
      tick;                                   // c4: new DRAIN
      ref_req = 1'b0;
      checks++;
      if (hold_user !== 1'b1 || ref_busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_restart: got hold=%b busy=%b expected 1/1", hold_user, ref_busy);
      end
      tick;                                   // c5
      checks++;
      if (cmd_valid !== 1'b1 || cmd_type !== 2'd2) begin
         failures++;
         $display("FAIL b2b_ref: got valid=%b type=%0d expected 1/2", cmd_valid, cmd_type);
      end
      repeat (2) tick;
   endtask

`ifdef REF_STATS_EN
   task automatic test_stats;
      int delays [3] = '{0, 6, 2};
      reset_n = 1'b0;
      tick;
      reset_n = 1'b1;
      bank_open = '0; tRFC = 16'd1; cmd_grant = 1'b1;
      tick;
      checks++;
      if (ref_count !== 16'd0 || max_ref_latency !== 16'd0) begin
         failures++;
         $display("FAIL stats_reset: got %0d/%0d expected 0/0", ref_count, max_ref_latency);
      end
      foreach (delays[k]) begin
         user_idle = (delays[k] == 0);
         ref_req = 1'b1;
         tick;                                // first DRAIN cycle
         ref_req = 1'b0;
         repeat (delays[k]) tick;
         user_idle = 1'b1;
         repeat (4) tick;
      end
      checks++;
      if (ref_count !== 16'd3) begin
         failures++;
         $display("FAIL stats_count: got %0d expected 3", ref_count);
      end
      checks++;
      if (max_ref_latency !== 16'd8) begin
         failures++;
         $display("FAIL stats_max_latency: got %0d expected 8", max_ref_latency);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_banks_closed;
      tick;
      test_banks_open;
      tick;
      test_drain;
      tick;
      test_grant_stall;
      tick;
      test_reset_mid;
      tick;
      test_back_to_back;
`ifdef REF_STATS_EN
      test_stats;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
